hsid_mse_scan_ctrl: RTL and testbench
=====================================

Name: hsid_mse_scan_ctrl

Overview:
- Sequencer for the hsid_mse datapath.
- On `start`, streams one pixel vector against every library vector. Both are read from synchronous band-pack memories with 1-cycle read latency.
- Drives the MSE stream handshake (`band_pack_start`/`last`/`valid`, `vctr_ref`) and collects the returned MSE results.
- Reports the best match (minimum non-overflowed MSE) to the HSID top-level control/register block.

Parameters:
- WORD_WIDTH, 32, width of one band pack (two bands per word).
- HSP_BANDS_WIDTH, 9, width of the band-count field.
- HSP_LIBRARY_WIDTH, 8, width of the library index/size field.
- LIB_ADDR_WIDTH, HSP_LIBRARY_WIDTH+HSP_BANDS_WIDTH-1, library memory word-address width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  start scan pulse; ignored while busy
- hsi_bands  in  HSP_BANDS_WIDTH  band count; packs = hsi_bands>>1
- library_size  in  HSP_LIBRARY_WIDTH  number of library vectors to compare
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse, results valid
- pix_rd_en  out  1  pixel memory read enable
- pix_rd_addr  out  HSP_BANDS_WIDTH-1  pixel pack address
- pix_rd_data  in  WORD_WIDTH  pixel pack data, valid the cycle after pix_rd_en
- lib_rd_en  out  1  library memory read enable
- lib_rd_addr  out  LIB_ADDR_WIDTH  library pack address, linear: ref*packs+pack
- lib_rd_data  in  WORD_WIDTH  library pack data, valid the cycle after lib_rd_en
- mse_clear  out  1  clear pulse to hsid_mse
- band_pack_start  out  1  first pack of a vector
- band_pack_last  out  1  last pack of a vector
- band_pack_valid  out  1  pack valid
- band_pack_a  out  WORD_WIDTH  equals pix_rd_data
- band_pack_b  out  WORD_WIDTH  equals lib_rd_data
- vctr_ref  out  HSP_LIBRARY_WIDTH  library index of the current vector
- mse_value  in  WORD_WIDTH  MSE result
- mse_ref  in  HSP_LIBRARY_WIDTH  result library index
- mse_valid  in  1  result strobe
- mse_of  in  1  result overflowed
- min_mse_value  out  WORD_WIDTH  best MSE
- min_mse_ref  out  HSP_LIBRARY_WIDTH  best index
- of_count  out  HSP_LIBRARY_WIDTH  number of overflowed results

Behaviour:
- **Reset (rst_n low at a clock edge):**
  - FSM goes to IDLE.
  - All outputs are 0, except min_mse_value, which is all-ones.
  - Reset mid-scan aborts immediately; no `done` pulse.
- **FSM: IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE.**
- **IDLE:**
  - `start` latches hsi_bands and library_size.
  - Latched values are held constant for the whole scan.
- **CLEAR (1 cycle):**
  - mse_clear=1, busy=1.
  - Resets min_mse_value to all-ones, min_mse_ref to 0, of_count to 0, and the pack, ref and result counters.
  - If packs==0 or library_size==0, go directly to DONE.
- **STREAM:** one read per cycle.
  - pix_rd_en=lib_rd_en=1.
  - pix_rd_addr=pack.
  - lib_rd_addr increments by 1 each issue.
  - pack wraps from packs-1 to 0 and ref increments.
  - Issue-side start/last/ref are registered one stage, aligned with read data. band_pack_valid is asserted exactly 1 cycle after the read, with band_pack_start at pack 0, band_pack_last at pack packs-1, and vctr_ref=ref.
  - packs==1: start and last are asserted on the same beat.
  - After issuing the final pack of ref library_size-1, go to DRAIN.
- **DRAIN:**
  - No reads.
  - Wait until results received == library_size.
- **Result collection (STREAM or DRAIN), on mse_valid:**
  - If mse_of=1, of_count++.
  - Else if mse_value < min_mse_value, update min_mse_value and min_mse_ref from mse_value/mse_ref.
  - Ties keep the earlier (lower) ref.
  - mse_valid outside a scan is ignored.
- **DONE (1 cycle):**
  - done=1, busy=0; return to IDLE.
  - Result outputs hold until the next CLEAR.
- **Other rules:**
  - Odd hsi_bands: the LSB is ignored.
  - `start` in DONE is ignored; `start` is accepted in IDLE only.

Optional Feature:
- Macro: HSID_MSE_SCAN_PAUSE_EN.
- **Defined:** adds input port `pause` (1 bit).
  - While pause=1 in STREAM: no reads are issued and counters freeze.
  - The in-flight beat still emits band_pack_valid next cycle; band_pack_valid is 0 afterwards.
  - Resumes without gaps in pack order.
  - pause in any other state has no effect.
- **Undefined:** port absent; STREAM issues every cycle.

Test Plan:
- **Normal scan.** hsi_bands=8, library_size=3, memory yields MSEs 40,12,25 -> min_mse_value=12, min_mse_ref=1, of_count=0, done pulses once. Also check 12 valid beats with start on beats 0/4/8 and last on beats 3/7/11.
- **Overflow and ties.** MSEs 5(of=1), 9, 9 -> min=9, ref=1, of_count=1.
- **Zero-size scans.** library_size=0, then separately hsi_bands=1 -> done 2 cycles after start, no reads, min=all-ones, min_mse_ref=0.
- **Reset and start-while-busy.** Deassert rst_n mid-STREAM -> next cycle busy=0, no done, all outputs at reset values. A `start` while busy is ignored.
- **Single pack.** hsi_bands=2, library_size=4 -> every beat has start=last=1; vctr_ref sequence 0,1,2,3.
- **Pause (with HSID_MSE_SCAN_PAUSE_EN).** pause for 3 cycles mid-vector -> pack order unchanged, results identical to the unpaused run, done delayed by 3 cycles.

Source files
------------

// File: rtl/hsid_mse_scan_ctrl.sv
// hsid_mse_scan_ctrl
// Sequencer for the hsid_mse datapath. On start it streams one pixel vector
// against every library vector, reading both from synchronous band-pack
// memories. It drives the MSE stream handshake, collects the returned results
// and keeps the best (lowest, non-overflowed) match.
// Optional feature: define HSID_MSE_SCAN_PAUSE_EN to add a 'pause' input that
// stalls read issue while in STREAM.
module hsid_mse_scan_ctrl #(
  parameter int WORD_WIDTH        = 32,
  parameter int HSP_BANDS_WIDTH   = 9,
  parameter int HSP_LIBRARY_WIDTH = 8,
  parameter int LIB_ADDR_WIDTH    = HSP_LIBRARY_WIDTH + HSP_BANDS_WIDTH - 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [HSP_BANDS_WIDTH-1:0]   hsi_bands,
  input  logic [HSP_LIBRARY_WIDTH-1:0] library_size,
`ifdef HSID_MSE_SCAN_PAUSE_EN
  input  logic                         pause,
`endif
  output logic                         busy,
  output logic                         done,
  output logic                         pix_rd_en,
  output logic [HSP_BANDS_WIDTH-2:0]   pix_rd_addr,
  input  logic [WORD_WIDTH-1:0]        pix_rd_data,
  output logic                         lib_rd_en,
  output logic [LIB_ADDR_WIDTH-1:0]    lib_rd_addr,
  input  logic [WORD_WIDTH-1:0]        lib_rd_data,
  output logic                         mse_clear,
  output logic                         band_pack_start,
  output logic                         band_pack_last,
  output logic                         band_pack_valid,
  output logic [WORD_WIDTH-1:0]        band_pack_a,
  output logic [WORD_WIDTH-1:0]        band_pack_b,
  output logic [HSP_LIBRARY_WIDTH-1:0] vctr_ref,
  input  logic [WORD_WIDTH-1:0]        mse_value,
  input  logic [HSP_LIBRARY_WIDTH-1:0] mse_ref,
  input  logic                         mse_valid,
  input  logic                         mse_of,
  output logic [WORD_WIDTH-1:0]        min_mse_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] min_mse_ref,
  output logic [HSP_LIBRARY_WIDTH-1:0] of_count
);

  localparam int PACK_W = HSP_BANDS_WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Scan configuration, frozen for the whole scan
  logic [HSP_BANDS_WIDTH-1:0]   bands_q;
  logic [HSP_LIBRARY_WIDTH-1:0] lsize_q;

  // Issue-side counters
  logic [PACK_W-1:0]            pack_q;
  logic [HSP_LIBRARY_WIDTH-1:0] ref_q;
  logic [LIB_ADDR_WIDTH-1:0]    addr_q;
  logic [HSP_LIBRARY_WIDTH-1:0] res_cnt_q;

  // Beat stage aligned with the memory read data
  logic                         beat_valid_q;
  logic                         beat_start_q;
  logic                         beat_last_q;
  logic [HSP_LIBRARY_WIDTH-1:0] beat_ref_q;

  // Best-match results
  logic [WORD_WIDTH-1:0]        min_q;
  logic [HSP_LIBRARY_WIDTH-1:0] min_ref_q;
  logic [HSP_LIBRARY_WIDTH-1:0] of_cnt_q;

  // Pack count is bands/2; the odd band (LSB) is dropped by the shift.
  logic [HSP_BANDS_WIDTH-1:0] packs;
  logic                       packs_zero;
  logic                       pack_is_last;
  logic                       ref_is_last;
  logic                       issue;
  logic                       collect;

  assign packs        = bands_q >> 1;
  assign packs_zero   = (packs == '0);
  assign pack_is_last = ({1'b0, pack_q} == packs - HSP_BANDS_WIDTH'(1));
  assign ref_is_last  = (ref_q == lsize_q - HSP_LIBRARY_WIDTH'(1));

`ifdef HSID_MSE_SCAN_PAUSE_EN
  assign issue = (state_q == S_STREAM) && !pause;
`else
  assign issue = (state_q == S_STREAM);
`endif

  // Results are only accepted while a scan is actually running.
  assign collect = mse_valid && ((state_q == S_STREAM) || (state_q == S_DRAIN));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control outputs
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    mse_clear = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        busy      = 1'b1;
        mse_clear = 1'b1;
        if (packs_zero || (lsize_q == '0)) state_d = S_DONE;
        else                               state_d = S_STREAM;
      end
      S_STREAM: begin
        busy = 1'b1;
        if (issue && pack_is_last && ref_is_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (res_cnt_q == lsize_q) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the scan configuration when a start is accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bands_q <= '0;
      lsize_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      bands_q <= hsi_bands;
      lsize_q <= library_size;
    end
  end

  // Pack / ref / address / result counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pack_q    <= '0;
      ref_q     <= '0;
      addr_q    <= '0;
      res_cnt_q <= '0;
    end else if (state_q == S_CLEAR) begin
      pack_q    <= '0;
      ref_q     <= '0;
      addr_q    <= '0;
      res_cnt_q <= '0;
    end else begin
      if (issue) begin
        addr_q <= addr_q + LIB_ADDR_WIDTH'(1);
        if (pack_is_last) begin
          pack_q <= '0;
          ref_q  <= ref_q + HSP_LIBRARY_WIDTH'(1);
        end else begin
          pack_q <= pack_q + PACK_W'(1);
        end
      end
      if (collect) res_cnt_q <= res_cnt_q + HSP_LIBRARY_WIDTH'(1);
    end
  end

  // Delay issue-side markers one cycle to line up with the read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_valid_q <= 1'b0;
      beat_start_q <= 1'b0;
      beat_last_q  <= 1'b0;
      beat_ref_q   <= '0;
    end else begin
      beat_valid_q <= issue;
      beat_start_q <= issue && (pack_q == '0);
      beat_last_q  <= issue && pack_is_last;
      if (issue) beat_ref_q <= ref_q;
    end
  end

  // Track the minimum MSE; strict compare keeps the earlier ref on ties
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_q     <= '1;
      min_ref_q <= '0;
      of_cnt_q  <= '0;
    end else if (state_q == S_CLEAR) begin
      min_q     <= '1;
      min_ref_q <= '0;
      of_cnt_q  <= '0;
    end else if (collect) begin
      if (mse_of) begin
        of_cnt_q <= of_cnt_q + HSP_LIBRARY_WIDTH'(1);
      end else if (mse_value < min_q) begin
        min_q     <= mse_value;
        min_ref_q <= mse_ref;
      end
    end
  end

  assign pix_rd_en       = issue;
  assign lib_rd_en       = issue;
  assign pix_rd_addr     = pack_q;
  assign lib_rd_addr     = addr_q;
  assign band_pack_valid = beat_valid_q;
  assign band_pack_start = beat_start_q;
  assign band_pack_last  = beat_last_q;
  assign vctr_ref        = beat_ref_q;
  assign band_pack_a     = pix_rd_data;
  assign band_pack_b     = lib_rd_data;
  assign min_mse_value   = min_q;
  assign min_mse_ref     = min_ref_q;
  assign of_count        = of_cnt_q;

endmodule

// File: tb/tb_hsid_mse_scan_ctrl.sv
// Directed testbench for hsid_mse_scan_ctrl. Models the pixel/library
// memories (1-cycle read latency) and a fixed-latency MSE unit that returns a
// table value per library vector after each vector's last beat.
module tb_hsid_mse_scan_ctrl;

  localparam int WW = 32;
  localparam int BW = 9;
  localparam int LW = 8;
  localparam int AW = LW + BW - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [BW-1:0] hsi_bands;
  logic [LW-1:0] library_size;
`ifdef HSID_MSE_SCAN_PAUSE_EN
  logic          pause;
`endif
  logic          busy, done, pix_rd_en, lib_rd_en, mse_clear;
  logic [BW-2:0] pix_rd_addr;
  logic [AW-1:0] lib_rd_addr;
  logic [WW-1:0] pix_rd_data = '0;
  logic [WW-1:0] lib_rd_data = '0;
  logic          band_pack_start, band_pack_last, band_pack_valid;
  logic [WW-1:0] band_pack_a, band_pack_b;
  logic [LW-1:0] vctr_ref;
  logic [WW-1:0] mse_value;
  logic [LW-1:0] mse_ref;
  logic          mse_valid, mse_of;
  logic [WW-1:0] min_mse_value;
  logic [LW-1:0] min_mse_ref;
  logic [LW-1:0] of_count;

  always #5 clk = ~clk;

  hsid_mse_scan_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .hsi_bands       (hsi_bands),
    .library_size    (library_size),
`ifdef HSID_MSE_SCAN_PAUSE_EN
    .pause           (pause),
`endif
    .busy            (busy),
    .done            (done),
    .pix_rd_en       (pix_rd_en),
    .pix_rd_addr     (pix_rd_addr),
    .pix_rd_data     (pix_rd_data),
    .lib_rd_en       (lib_rd_en),
    .lib_rd_addr     (lib_rd_addr),
    .lib_rd_data     (lib_rd_data),
    .mse_clear       (mse_clear),
    .band_pack_start (band_pack_start),
    .band_pack_last  (band_pack_last),
    .band_pack_valid (band_pack_valid),
    .band_pack_a     (band_pack_a),
    .band_pack_b     (band_pack_b),
    .vctr_ref        (vctr_ref),
    .mse_value       (mse_value),
    .mse_ref         (mse_ref),
    .mse_valid       (mse_valid),
    .mse_of          (mse_of),
    .min_mse_value   (min_mse_value),
    .min_mse_ref     (min_mse_ref),
    .of_count        (of_count)
  );

  // Memory models: data is a tagged copy of the address.
  always @(posedge clk) begin
    if (pix_rd_en) pix_rd_data <= 32'hA000_0000 | 32'(pix_rd_addr);
    if (lib_rd_en) lib_rd_data <= 32'hB000_0000 | 32'(lib_rd_addr);
  end

  // MSE unit model: result two cycles after a vector's last beat.
  logic [WW-1:0] mse_tab [8];
  logic          of_tab  [8];
  logic          r1_v = 1'b0, r2_v = 1'b0;
  logic [LW-1:0] r1_ref = '0, r2_ref = '0;
  logic          stray;
  always @(posedge clk) begin
    r1_v   <= band_pack_valid & band_pack_last;
    r1_ref <= vctr_ref;
    r2_v   <= r1_v;
    r2_ref <= r1_ref;
  end
  assign mse_valid = r2_v | stray;
  assign mse_ref   = stray ? '0 : r2_ref;
  assign mse_value = stray ? 32'd1 : mse_tab[r2_ref[2:0]];
  assign mse_of    = stray ? 1'b0 : of_tab[r2_ref[2:0]];

  // Cycle counter and output monitor (samples 1 time unit after the edge)
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          beats = 0, reads = 0, done_cnt = 0, done_cyc = 0;
  logic        bs [256];
  logic        bl [256];
  logic [LW-1:0] br [256];
  logic [WW-1:0] ba [256];
  logic [WW-1:0] bb [256];
  always @(posedge clk) begin
    #1;
    if (band_pack_valid) begin
      if (beats < 256) begin
        bs[beats] = band_pack_start;
        bl[beats] = band_pack_last;
        br[beats] = vctr_ref;
        ba[beats] = band_pack_a;
        bb[beats] = band_pack_b;
      end
      beats++;
    end
    if (pix_rd_en) reads++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_tab(input int v0, input int v1, input int v2, input int v3,
                         input logic o0, input logic o1, input logic o2, input logic o3);
    mse_tab[0] = 32'(v0); mse_tab[1] = 32'(v1); mse_tab[2] = 32'(v2); mse_tab[3] = 32'(v3);
    of_tab[0] = o0; of_tab[1] = o1; of_tab[2] = o2; of_tab[3] = o3;
    for (int i = 4; i < 8; i++) begin
      mse_tab[i] = 32'hFFFF_FFFF;
      of_tab[i]  = 1'b0;
    end
  endtask

  // Run one scan; optional extra start pulse (k index) and 3-cycle pause.
  task automatic do_scan(input int bands, input int size, input int extra_at,
                         input int pause_at, output int dur);
    int d0, k;
    d0 = done_cnt;
    @(negedge clk);
    hsi_bands    = BW'(bands);
    library_size = LW'(size);
    start        = 1'b1;
    dur          = cyc;
    k            = 0;
    do begin
      @(negedge clk);
      if (k == 0) begin
        chk("clear_busy", 64'(busy), 64'd1);
        chk("clear_pulse", 64'(mse_clear), 64'd1);
      end
      start = (k == extra_at);
      if (k == extra_at) begin
        hsi_bands    = BW'(6);
        library_size = LW'(1);
      end
`ifdef HSID_MSE_SCAN_PAUSE_EN
      pause = (pause_at >= 0) && (k >= pause_at) && (k < pause_at + 3);
`endif
      k++;
    end while ((done_cnt == d0) && (k < 2000));
    start = 1'b0;
`ifdef HSID_MSE_SCAN_PAUSE_EN
    pause = 1'b0;
`endif
    chk("done_seen", 64'(done_cnt != d0), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    dur = done_cyc - dur;
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    $display("scan bands=%0d size=%0d cycles=%0d min=%0h ref=%0d of=%0d",
             bands, size, dur, min_mse_value, min_mse_ref, of_count);
  endtask

  task automatic chk_beats(input int b0, input int packs, input int size);
    int n;
    n = packs * size;
    for (int k = 0; k < n; k++) begin
      chk("beat_start", 64'(bs[b0+k]), 64'((k % packs) == 0));
      chk("beat_last",  64'(bl[b0+k]), 64'((k % packs) == packs - 1));
      chk("beat_ref",   64'(br[b0+k]), 64'(k / packs));
      chk("beat_a",     64'(ba[b0+k]), 64'(32'hA000_0000 | 32'(k % packs)));
      chk("beat_b",     64'(bb[b0+k]), 64'(32'hB000_0000 | 32'(k)));
    end
  endtask

  task automatic chk_res(input logic [31:0] mn, input int rf, input int ofc);
    chk("min_value", 64'(min_mse_value), 64'(mn));
    chk("min_ref",   64'(min_mse_ref),   64'(rf));
    chk("of_count",  64'(of_count),      64'(ofc));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_done",   64'(done), 64'd0);
    chk("rst_clear",  64'(mse_clear), 64'd0);
    chk("rst_pix_en", 64'(pix_rd_en), 64'd0);
    chk("rst_lib_en", 64'(lib_rd_en), 64'd0);
    chk("rst_pix_ad", 64'(pix_rd_addr), 64'd0);
    chk("rst_lib_ad", 64'(lib_rd_addr), 64'd0);
    chk("rst_valid",  64'(band_pack_valid), 64'd0);
    chk("rst_start",  64'(band_pack_start), 64'd0);
    chk("rst_last",   64'(band_pack_last), 64'd0);
    chk("rst_vref",   64'(vctr_ref), 64'd0);
    chk_res(32'hFFFF_FFFF, 0, 0);
  endtask

  int dur_norm, dur, b0, r0, d0;

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    hsi_bands    = '0;
    library_size = '0;
    stray        = 1'b0;
`ifdef HSID_MSE_SCAN_PAUSE_EN
    pause        = 1'b0;
`endif
    set_tab(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Normal scan: 4 packs x 3 refs, MSEs 40,12,25
    set_tab(40, 12, 25, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    b0 = beats; r0 = reads;
    do_scan(8, 3, -1, -1, dur_norm);
    chk("n_beats", 64'(beats - b0), 64'd12);
    chk("n_reads", 64'(reads - r0), 64'd12);
    chk_beats(b0, 4, 3);
    chk_res(32'd12, 1, 0);

    // Stray result while idle must be ignored
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    @(negedge clk);
    chk_res(32'd12, 1, 0);

    // Overflow and ties
    set_tab(5, 9, 9, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    b0 = beats;
    do_scan(4, 3, -1, -1, dur);
    chk("of_beats", 64'(beats - b0), 64'd6);
    chk_res(32'd9, 1, 1);

    // Zero library size
    b0 = beats; r0 = reads;
    do_scan(8, 0, -1, -1, dur);
    chk("zlib_dur", 64'(dur), 64'd2);
    chk("zlib_reads", 64'(reads - r0), 64'd0);
    chk("zlib_beats", 64'(beats - b0), 64'd0);
    chk_res(32'hFFFF_FFFF, 0, 0);

    // Zero packs (hsi_bands=1)
    set_tab(5, 9, 9, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    b0 = beats; r0 = reads;
    do_scan(1, 3, -1, -1, dur);
    chk("zpk_dur", 64'(dur), 64'd2);
    chk("zpk_reads", 64'(reads - r0), 64'd0);
    chk("zpk_beats", 64'(beats - b0), 64'd0);
    chk_res(32'hFFFF_FFFF, 0, 0);

    // Single pack per vector
    set_tab(7, 3, 3, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    b0 = beats;
    do_scan(2, 4, -1, -1, dur);
    chk("sp_beats", 64'(beats - b0), 64'd4);
    chk_beats(b0, 1, 4);
    chk_res(32'd3, 1, 0);

    // Start while busy (with changed config) is ignored; odd bands=5 -> 2 packs
    set_tab(6, 4, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    b0 = beats;
    do_scan(5, 2, 2, -1, dur);
    chk("sb_beats", 64'(beats - b0), 64'd4);
    chk_beats(b0, 2, 2);
    chk_res(32'd4, 1, 0);

    // Reset mid-STREAM: abort, no done, outputs at reset values
    set_tab(40, 12, 25, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    d0 = done_cnt;
    @(negedge clk);
    hsi_bands = BW'(8); library_size = LW'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("rst_idle_busy", 64'(busy), 64'd0);
    chk_res(32'hFFFF_FFFF, 0, 0);

`ifdef HSID_MSE_SCAN_PAUSE_EN
    // Pause 3 cycles mid-vector: same beats and results, 3 cycles later
    set_tab(40, 12, 25, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    b0 = beats; r0 = reads;
    do_scan(8, 3, -1, 3, dur);
    chk("pz_dur", 64'(dur), 64'(dur_norm + 3));
    chk("pz_beats", 64'(beats - b0), 64'd12);
    chk("pz_reads", 64'(reads - r0), 64'd12);
    chk_beats(b0, 4, 3);
    chk_res(32'd12, 1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
